// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit: the carry chain is cut into STAGES registered chunks with valid/ready flow control.
// Optional signed saturation of the result on overflow is enabled by defining PIPELINED_ADDSUB_SAT_EN.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dina,
  input  logic [WIDTH-1:0] dinb,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;

  logic             valid_reg [STAGES];
  logic [WIDTH-1:0] a_reg     [STAGES];
  logic [WIDTH-1:0] b_reg     [STAGES];
  logic [WIDTH-1:0] sum_reg   [STAGES];
  logic             carry_reg [STAGES];
  logic             ovf_reg;

  logic             src_valid [STAGES];
  logic [WIDTH-1:0] src_a     [STAGES];
  logic [WIDTH-1:0] src_b     [STAGES];
  logic [WIDTH-1:0] src_sum   [STAGES];
  logic             src_carry [STAGES];
  logic [WIDTH-1:0] sum_next  [STAGES];
  logic             carry_next[STAGES];
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0] dout_next;
  logic             ovf_next;

  // Stage k consumes the registers of stage k-1; stage 0 consumes the input port directly.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        src_valid[k] = in_valid;
        src_a[k]     = dina;
        src_b[k]     = sub ? ~dinb : dinb;
        src_sum[k]   = '0;
        src_carry[k] = sub;
      end else begin
        src_valid[k] = valid_reg[k-1];
        src_a[k]     = a_reg[k-1];
        src_b[k]     = b_reg[k-1];
        src_sum[k]   = sum_reg[k-1];
        src_carry[k] = carry_reg[k-1];
      end
    end
  end

  // Advance chain runs from the output back to the input so empty middle slots keep filling during a stall.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = !valid_reg[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = !valid_reg[k] || adv[k+1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [CW:0]      chunk;
      logic [WIDTH-1:0] merged;

      assign chunk = {1'b0, src_a[gi][gi*CW +: CW]}
                   + {1'b0, src_b[gi][gi*CW +: CW]}
                   + {{CW{1'b0}}, src_carry[gi]};

      always_comb begin
        merged = src_sum[gi];
        merged[gi*CW +: CW] = chunk[CW-1:0];
      end

      assign sum_next[gi]   = merged;
      assign carry_next[gi] = chunk[CW];
    end
  endgenerate

  always_comb begin
    ovf_next = (src_a[STAGES-1][WIDTH-1] == src_b[STAGES-1][WIDTH-1]) &&
               (sum_next[STAGES-1][WIDTH-1] != src_a[STAGES-1][WIDTH-1]);
`ifdef PIPELINED_ADDSUB_SAT_EN
    dout_next = ovf_next ? {src_a[STAGES-1][WIDTH-1], {(WIDTH-1){!src_a[STAGES-1][WIDTH-1]}}}
                         : sum_next[STAGES-1];
`else
    dout_next = sum_next[STAGES-1];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_reg[k] <= 1'b0;
        a_reg[k]     <= '0;
        b_reg[k]     <= '0;
        sum_reg[k]   <= '0;
        carry_reg[k] <= 1'b0;
      end
      ovf_reg <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          valid_reg[k] <= src_valid[k];
          // Payload only moves with a real beat, so outputs keep their last value when idle.
          if (src_valid[k]) begin
            a_reg[k]     <= src_a[k];
            b_reg[k]     <= src_b[k];
            carry_reg[k] <= carry_next[k];
            sum_reg[k]   <= (k == STAGES - 1) ? dout_next : sum_next[k];
          end
        end
      end
      if (adv[STAGES-1] && src_valid[STAGES-1]) begin
        ovf_reg <= ovf_next;
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_reg[STAGES-1];
  assign dout      = sum_reg[STAGES-1];
  assign cout      = carry_reg[STAGES-1];
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: STAGES=4 unit under flow-control tests, STAGES=1 and STAGES=32 units alongside for the sweep.
module tb_pipelined_addsub;

  localparam int DEPTH = 512;

  typedef struct packed {
    logic [31:0] d;
    logic        c;
    logic        o;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    res_t        r;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] dina = '0;
  logic [31:0] dinb = '0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b0;

  logic        rdy4, rdy1, rdy32, ov4, ov1, ov32, co4, co1, co32, of4, of1, of32;
  logic [31:0] dout4, dout1, dout32;
  logic [2:0]  rdy, ov, co, of;
  logic [2:0][31:0] dq;

  assign rdy = {rdy32, rdy1, rdy4};
  assign ov  = {ov32, ov1, ov4};
  assign co  = {co32, co1, co4};
  assign of  = {of32, of1, of4};
  assign dq  = {dout32, dout1, dout4};

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4), .dina(dina), .dinb(dinb),
    .sub(sub), .out_valid(ov4), .out_ready(out_ready), .dout(dout4), .cout(co4), .ovf(of4));

  pipelined_addsub #(.WIDTH(32), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .dina(dina), .dinb(dinb),
    .sub(sub), .out_valid(ov1), .out_ready(1'b1), .dout(dout1), .cout(co1), .ovf(of1));

  pipelined_addsub #(.WIDTH(32), .STAGES(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32), .dina(dina), .dinb(dinb),
    .sub(sub), .out_valid(ov32), .out_ready(1'b1), .dout(dout32), .cout(co32), .ovf(of32));

  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  logic acc4 = 1'b0;
  logic lat_chk = 1'b0;
  res_t cur_exp;
  res_t sb  [3][DEPTH];
  int   sbc [3][DEPTH];
  int   wp [3] = '{0, 0, 0};
  int   rp [3] = '{0, 0, 0};
  int   stg[3] = '{4, 1, 32};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Independent reference: signed wide arithmetic for overflow, unsigned compare for carry/borrow.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    res_t   r;
    longint sa, sbv, full;
    logic [63:0] ua, ub;
    sa   = longint'($signed(a));
    sbv  = longint'($signed(b));
    full = s ? (sa - sbv) : (sa + sbv);
    ua   = {32'b0, a};
    ub   = {32'b0, b};
    r.o  = (full > 64'sd2147483647) || (full < -64'sd2147483648);
    r.c  = s ? (ua >= ub) : ((ua + ub) >= 64'h1_0000_0000);
    r.d  = full[31:0];
`ifdef PIPELINED_ADDSUB_SAT_EN
    if (r.o) r.d = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return r;
  endfunction

  // One clock: sample at the falling edge, score outputs, record accepts, return just after the rising edge.
  task automatic tick();
    res_t e;
    @(negedge clk);
    cyc++;
    acc4 = in_valid && rdy[0];
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        wp[d] = 0;
        rp[d] = 0;
      end else begin
        if (ov[d] && ((d != 0) || out_ready)) begin
          if (rp[d] == wp[d]) begin
            chk($sformatf("dut%0d unexpected beat out_valid", stg[d]), {63'b0, ov[d]}, 64'd0);
          end else begin
            e = sb[d][rp[d] % DEPTH];
            chk($sformatf("dut%0d result {dout,cout,ovf}", stg[d]), {30'b0, dq[d], co[d], of[d]}, {30'b0, e});
            if ((d != 0) || lat_chk)
              chk($sformatf("dut%0d latency", stg[d]), 64'(cyc - sbc[d][rp[d] % DEPTH]), 64'(stg[d]));
            rp[d]++;
          end
        end else if (ov[d] && (rp[d] != wp[d])) begin
          e = sb[d][rp[d] % DEPTH];
          chk($sformatf("dut%0d stalled hold {dout,cout,ovf}", stg[d]), {30'b0, dq[d], co[d], of[d]}, {30'b0, e});
        end
        if (in_valid && rdy[d]) begin
          sb[d][wp[d] % DEPTH]  = cur_exp;
          sbc[d][wp[d] % DEPTH] = cyc;
          wp[d]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s, input res_t r);
    in_valid = 1'b1;
    dina     = a;
    dinb     = b;
    sub      = s;
    cur_exp  = r;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input res_t r,
                      output int waited);
    drive(a, b, s, r);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!acc4 && waited < 40);
    if (!acc4) chk("accept within budget", {63'b0, acc4}, 64'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[9];
    logic [31:0] bpa[6];
    logic [31:0] bpb[6];
    logic [31:0] ra, rb;
    logic        rs;
    int          w, idx, n;
    bit          busy;

    tbl[0] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, '{32'h0001_0000, 1'b0, 1'b0}};
    tbl[1] = '{32'h0000_0005, 32'h0000_0007, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0}};
`ifdef PIPELINED_ADDSUB_SAT_EN
    tbl[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, '{32'h8000_0000, 1'b1, 1'b1}};
    tbl[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, '{32'h7FFF_FFFF, 1'b0, 1'b1}};
    tbl[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, '{32'h8000_0000, 1'b1, 1'b1}};
    tbl[8] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, '{32'h7FFF_FFFF, 1'b0, 1'b1}};
`else
    tbl[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1}};
    tbl[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, '{32'h8000_0000, 1'b0, 1'b1}};
    tbl[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, '{32'h0000_0000, 1'b1, 1'b1}};
    tbl[8] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, '{32'h8000_0000, 1'b0, 1'b1}};
`endif
    tbl[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, '{32'h0000_0000, 1'b1, 1'b0}};
    tbl[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, '{32'h0000_0000, 1'b1, 1'b0}};
    tbl[6] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, '{32'hACF1_3568, 1'b0, 1'b0}};

    // Reset state.
    #2;
    chk("reset out_valid", {63'b0, ov[0]}, 64'd0);
    chk("reset dout", {32'b0, dq[0]}, 64'd0);
    chk("reset cout", {63'b0, co[0]}, 64'd0);
    chk("reset ovf", {63'b0, of[0]}, 64'd0);
    chk("reset in_ready", {63'b0, rdy[0]}, 64'd1);
    chk("reset dut32 in_ready", {63'b0, rdy[2]}, 64'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Directed vectors, back to back, with exact latency checking.
    out_ready = 1'b1;
    lat_chk   = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].r, w);
      chk($sformatf("table[%0d] accepted first cycle", i), 64'(w), 64'd1);
    end
    repeat (6) tick();
    lat_chk = 1'b0;

    // Backpressure: six beats offered with the output stalled.
    for (int i = 0; i < 6; i++) begin
      bpa[i] = $urandom;
      bpb[i] = $urandom;
    end
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      drive(bpa[idx], bpb[idx], idx[0], model(bpa[idx], bpb[idx], idx[0]));
      tick();
      chk($sformatf("backpressure accept c%0d", c), {63'b0, acc4}, {63'b0, (idx < 4)});
      if (acc4) idx++;
    end
    out_ready = 1'b1;
    n = 0;
    while (idx < 6 && n < 20) begin
      drive(bpa[idx], bpb[idx], idx[0], model(bpa[idx], bpb[idx], idx[0]));
      tick();
      if (acc4) idx++;
      n++;
    end
    in_valid = 1'b0;
    chk("backpressure all accepted", 64'(idx), 64'd6);
    repeat (8) tick();

    // Bubble collapse: gaps between beats must not reduce capacity while stalled.
    out_ready = 1'b0;
    ra = 32'h0000_1111; rb = 32'h0000_2222;
    send(ra, rb, 1'b0, model(ra, rb, 1'b0), w);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'(i);
      send(ra, rb, rs, model(ra, rb, rs), w);
      chk($sformatf("bubble beat %0d accepted at once", i + 1), 64'(w), 64'd1);
    end
    ra = 32'hDEAD_BEEF; rb = 32'h0000_0001;
    drive(ra, rb, 1'b1, model(ra, rb, 1'b1));
    tick();
    chk("bubble full blocks accept", {63'b0, acc4}, 64'd0);
    out_ready = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc4 && n < 10);
    in_valid = 1'b0;
    chk("bubble accept after release", {63'b0, acc4}, 64'd1);
    repeat (8) tick();

    // Reset with three beats in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom;
      send(ra, rb, 1'b0, model(ra, rb, 1'b0), w);
    end
    tick();
    chk("pre-reset out_valid", {63'b0, ov[0]}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", {63'b0, ov[0]}, 64'd0);
    chk("async reset dout", {32'b0, dq[0]}, 64'd0);
    chk("async reset in_ready", {63'b0, rdy[0]}, 64'd1);
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (8) tick();
    chk("post-reset in_ready", {63'b0, rdy[0]}, 64'd1);

    // Random traffic with random backpressure on the STAGES=4 unit.
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || acc4) begin
        case ($urandom_range(0, 3))
          0:       ra = 32'h8000_0000;
          1:       ra = 32'h7FFF_FFFF;
          default: ra = $urandom;
        endcase
        rb = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        rs = 1'($urandom_range(0, 1));
        drive(ra, rb, rs, model(ra, rb, rs));
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      busy = 1'b0;
      for (int d = 0; d < 3; d++) if (wp[d] != rp[d]) busy = 1'b1;
    end while (busy && n < 100);
    for (int d = 0; d < 3; d++)
      chk($sformatf("dut%0d drained, beats outstanding", stg[d]), 64'(wp[d] - rp[d]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined add/subtract unit; successor to the single-cycle combinational 32-bit adder.
- Splits the WIDTH-bit carry chain into STAGES registered segments, one segment per stage.
- Adds subtract mode, carry-out and signed overflow flags, and valid/ready flow control with per-stage bubble collapse.
- Sits in the EX stage of the dynamic pipeline; feeds the ALU result mux and the branch-target path.

Parameters:
- WIDTH, 32, operand/result width in bits; must satisfy WIDTH % STAGES == 0.
- STAGES, 4, number of pipeline segments (1..WIDTH); chunk size CW = WIDTH/STAGES.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit accepts a beat this cycle.
- dina  input  WIDTH  operand A.
- dinb  input  WIDTH  operand B.
- sub  input  1  1 = A - B, 0 = A + B.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts a result.
- dout  output  WIDTH  sum/difference.
- cout  output  1  carry out of MSB; in subtract mode, 1 = no borrow.
- ovf  output  1  signed two's-complement overflow.

Behaviour:
Reset:
- Clock is clk; reset rst_n is asynchronous, active-low.
- While rst_n = 0, all stage valid bits clear: out_valid = 0, dout = 0, cout = 0, ovf = 0, in_ready = 1.
- Reset mid-operation discards all in-flight beats. There is no partial flush.

Input and arithmetic:
- Accept occurs when in_valid && in_ready.
- On accept, stage 0 latches: A, B' = sub ? ~dinb : dinb, carry-in = sub, and its valid bit.
- Stage k (0..STAGES-1) computes chunk bits [k*CW +: CW] as A_chunk + B'_chunk + carry_in.
- Stage k registers the chunk result and the chunk carry-out into stage k+1, along with the still-unprocessed upper operand bits.
- Final stage registers the full result, cout (carry out of bit WIDTH-1) and ovf.
- ovf = (A[W-1] == B'[W-1]) && (dout[W-1] != A[W-1]).
- Latency: STAGES cycles from accept to out_valid when there is no backpressure. STAGES = 1 gives a registered single-cycle adder.
- Throughput: 1 beat per cycle.

Flow control:
- Stage i advances when it is empty OR stage i+1 advances.
- The final stage advances when out_valid = 0 OR out_ready = 1.
- in_ready = stage 0 empty OR stage 0 advances. This is combinational from out_ready through the chain; there is no skid buffer.
- Bubbles collapse: an empty middle stage is filled even while the output is stalled.
- Full condition: all STAGES slots valid and out_ready = 0 → in_ready = 0.
- While stalled: dout/cout/ovf/out_valid hold stable until accepted (no change while out_valid && !out_ready).
- Simultaneous accept and output in the same cycle when full and out_ready = 1: both happen; occupancy is unchanged.

Width rules:
- Results wrap modulo 2^WIDTH. No sign extension is performed.
- Operand bits above the current chunk travel unmodified through the stages.

Optional Feature:
- Macro: PIPELINED_ADDSUB_SAT_EN.
- Defined: when ovf = 1, dout is replaced by signed saturation:
  - 0x7FF..F if A[W-1] = 0;
  - 0x800..0 if A[W-1] = 1.
  - ovf still reports 1; cout is unchanged.
  - The saturation mux is applied in the final stage only, so latency is unchanged.
- Undefined: dout is the wrapped result; there is no saturation logic.

Test Plan (WIDTH=32, STAGES=4 unless stated):
- Reset: assert rst_n = 0 mid-stream with 3 beats in flight → out_valid drops immediately. After release, no stale beat appears; in_ready = 1.
- Carry across chunks, add: 0x0000_FFFF + 0x0000_0001, out_ready = 1 → dout = 0x0001_0000 and cout = 0, ovf = 0, exactly 4 cycles after accept.
- Subtract and flags: 0x0000_0005 - 0x0000_0007 → dout = 0xFFFF_FFFE, cout = 0, ovf = 0. Then 0x8000_0000 - 0x0000_0001 → dout = 0x7FFF_FFFF, cout = 1, ovf = 1. With PIPELINED_ADDSUB_SAT_EN, the second result is dout = 0x8000_0000.
- Backpressure: stream 6 back-to-back beats with out_ready = 0 → in_ready falls after exactly 4 accepts and dout holds stable. Raise out_ready → results appear in order, one per cycle, none lost or duplicated.
- Bubble collapse: send beat, idle 2 cycles, send beat, with out_ready held 0 → both beats pack into the last two stages. in_ready stays 1 until 4 beats are resident.
- Parameter sweep: STAGES = 1 and STAGES = 32 with WIDTH = 32, random operands against a reference model → latency equals STAGES, and results and flags match.
